// File: rtl/vec_pkg.sv
// Shared types and constants for the vector MAC datapath (feeder and vector_unit).
package vec_pkg;

  localparam int DATA_W   = 8;
  localparam int ACC_W    = 32;
  localparam int INT8_MIN = -128;
  localparam int INT8_MAX = 127;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_DRAIN,
    ST_HOLD
  } feeder_state_t;

endpackage

// File: rtl/requant_sat.sv
// Requantizes a wide accumulator to int8: round half up, arithmetic shift, saturate.
module requant_sat
  import vec_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc,
  input  logic        [4:0]        shift,
  output logic signed [DATA_W-1:0] sat
);

  localparam logic signed [ACC_W:0] SAT_HI = (ACC_W+1)'(INT8_MAX);
  localparam logic signed [ACC_W:0] SAT_LO = (ACC_W+1)'(INT8_MIN);

  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] shr;

  // One extra bit of headroom keeps the rounding add from wrapping.
  always_comb begin
    rnd = '0;
    if (shift != 5'd0) begin
      rnd = (ACC_W+1)'(1) <<< (shift - 5'd1);
    end
    sum = $signed({acc[ACC_W-1], acc}) + rnd;
    shr = sum >>> shift;
    if (shr > SAT_HI) begin
      sat = DATA_W'(INT8_MAX);
    end else if (shr < SAT_LO) begin
      sat = DATA_W'(INT8_MIN);
    end else begin
      sat = shr[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/vector_feeder.sv
// Buffers (x, w) operand pairs, streams them into one MAC lane, then captures
// and requantizes the accumulator behind a valid/ready result handshake.
module vector_feeder
  import vec_pkg::*;
#(
  parameter int MAX_LEN = 16,
  parameter int MAC_LAT = 2,
  parameter int ADDR_W  = $clog2(MAX_LEN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_x,
  input  logic signed [DATA_W-1:0] wr_w,
  input  logic                     start,
  input  logic [ADDR_W:0]          len,
  input  logic [4:0]               shift,
  output logic                     busy,
  output logic                     mac_clear,
  output logic signed [DATA_W-1:0] mac_x,
  output logic signed [DATA_W-1:0] mac_w,
  input  logic signed [ACC_W-1:0]  mac_accum,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [DATA_W-1:0] res_data,
  output logic signed [ACC_W-1:0]  res_raw
);

  localparam int CNT_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(MAC_LAT - 1);
  localparam logic [ADDR_W:0]  MAX_LEN_W  = (ADDR_W+1)'(MAX_LEN);

  logic signed [DATA_W-1:0] op_x_mem [MAX_LEN];
  logic signed [DATA_W-1:0] op_w_mem [MAX_LEN];

  feeder_state_t            state_reg;
  logic [ADDR_W:0]          len_reg;
  logic [4:0]               shift_reg;
  logic [ADDR_W:0]          idx_reg;
  logic [CNT_W-1:0]         drain_cnt_reg;
  logic                     busy_reg;
  logic                     mac_clear_reg;
  logic signed [DATA_W-1:0] mac_x_reg;
  logic signed [DATA_W-1:0] mac_w_reg;
  logic                     res_valid_reg;
  logic signed [DATA_W-1:0] res_data_reg;
  logic signed [ACC_W-1:0]  res_raw_reg;

  logic                     launch;
  logic                     wr_ok;
  logic [ADDR_W:0]          len_clamped;
  logic signed [DATA_W-1:0] requant_out;

  // A new job may start from IDLE, or from HOLD only when the result leaves that cycle.
  assign launch      = start && ((state_reg == ST_IDLE) || ((state_reg == ST_HOLD) && res_ready));
  assign wr_ok       = (state_reg == ST_IDLE) || (state_reg == ST_HOLD);
  assign len_clamped = (len > MAX_LEN_W) ? MAX_LEN_W : len;

  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      op_x_mem[wr_addr] <= wr_x;
      op_w_mem[wr_addr] <= wr_w;
    end
  end

  requant_sat u_requant (
    .acc   (mac_accum),
    .shift (shift_reg),
    .sat   (requant_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      len_reg       <= '0;
      shift_reg     <= '0;
      idx_reg       <= '0;
      drain_cnt_reg <= '0;
      busy_reg      <= 1'b0;
      mac_clear_reg <= 1'b0;
      mac_x_reg     <= '0;
      mac_w_reg     <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_raw_reg   <= '0;
    end else begin
      mac_clear_reg <= 1'b0;
      mac_x_reg     <= '0;
      mac_w_reg     <= '0;
      case (state_reg)
        ST_IDLE: ;
        ST_CLEAR: begin
          drain_cnt_reg <= '0;
          if (len_reg != '0) begin
            state_reg <= ST_STREAM;
            mac_x_reg <= op_x_mem[0];
            mac_w_reg <= op_w_mem[0];
            idx_reg   <= (ADDR_W+1)'(1);
          end else begin
            state_reg <= ST_DRAIN;
          end
        end
        ST_STREAM: begin
          if (idx_reg == len_reg) begin
            state_reg <= ST_DRAIN;
          end else begin
            mac_x_reg <= op_x_mem[idx_reg[ADDR_W-1:0]];
            mac_w_reg <= op_w_mem[idx_reg[ADDR_W-1:0]];
            idx_reg   <= idx_reg + (ADDR_W+1)'(1);
          end
        end
        ST_DRAIN: begin
          // The last drain cycle is the first one where every product is in the accumulator.
          if (drain_cnt_reg == LAST_DRAIN) begin
            res_raw_reg   <= mac_accum;
            res_data_reg  <= requant_out;
            res_valid_reg <= 1'b1;
            state_reg     <= ST_HOLD;
          end else begin
            drain_cnt_reg <= drain_cnt_reg + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
      if (launch) begin
        len_reg       <= len_clamped;
        shift_reg     <= shift;
        idx_reg       <= '0;
        busy_reg      <= 1'b1;
        mac_clear_reg <= 1'b1;
        state_reg     <= ST_CLEAR;
      end
    end
  end

  assign busy      = busy_reg;
  assign mac_clear = mac_clear_reg;
  assign mac_x     = mac_x_reg;
  assign mac_w     = mac_w_reg;
  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_raw   = res_raw_reg;

endmodule
